// File: rtl/mbc_gen2.sv
// mbc_gen2: clocked cartridge memory bank controller with a synchronised write strobe.
// Optional feature macro: MBC_GEN2_ZERO_BANK_FIX_EN (maps bank 0 to 1 in the 0x4000 window).
module mbc_gen2 #(
  parameter int ROM_BANK_W = 9,
  parameter int RAM_BANK_W = 4
) (
  input  logic                  CLK,
  input  logic                  n_RESET,
  input  logic [7:0]            D,
  input  logic                  A15,
  input  logic                  A14,
  input  logic                  A13,
  input  logic                  A12,
  input  logic                  n_WR,
  input  logic                  n_CS,
  output logic [ROM_BANK_W-1:0] RA,
  output logic [RAM_BANK_W-1:0] AA,
  output logic                  RAM_CS,
  output logic                  n_RAM_CS
);

  localparam int HI_W = (ROM_BANK_W > 8) ? ROM_BANK_W - 8 : 1;

  logic       wr_sync_p0;
  logic       wr_sync_p1;
  logic       wr_prev_p2;
  logic [1:0] settle_cnt;
  logic       armed;
  logic       vld_p2;

  logic [3:0] a_hold_p1;
  logic       ncs_hold_p1;
  logic [7:0] d_hold_p1;
  logic       commit;

  logic                  ram_en;
  logic [7:0]            rom_lo;
  logic [HI_W-1:0]       rom_hi;
  logic [RAM_BANK_W-1:0] ram_bank;
  logic                  mode;

  logic [ROM_BANK_W-1:0] rom_bank;
  logic [ROM_BANK_W-1:0] rom_hi_page;

  // Stage p0/p1: two-flop synchroniser; p2: edge flop.
  // armed only sets once a genuinely synchronised high level is seen after reset,
  // so a strobe already in progress at reset release can never commit.
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      wr_sync_p0 <= 1'b1;
      wr_sync_p1 <= 1'b1;
      wr_prev_p2 <= 1'b1;
      settle_cnt <= 2'd0;
      armed      <= 1'b0;
    end else begin
      wr_sync_p0 <= n_WR;
      wr_sync_p1 <= wr_sync_p0;
      wr_prev_p2 <= wr_sync_p1;
      if (settle_cnt != 2'd2)
        settle_cnt <= settle_cnt + 2'd1;
      if (settle_cnt == 2'd2 && wr_sync_p1)
        armed <= 1'b1;
    end
  end

  assign vld_p2 = wr_sync_p1 & ~wr_prev_p2 & armed;

  // Stage p1: bus hold registers track the bus while the synced strobe is low.
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      a_hold_p1   <= 4'h0;
      ncs_hold_p1 <= 1'b0;
      d_hold_p1   <= 8'h00;
    end else if (!wr_sync_p1) begin
      a_hold_p1   <= {A15, A14, A13, A12};
      ncs_hold_p1 <= n_CS;
      d_hold_p1   <= D;
    end
  end

  assign commit = vld_p2 & ~a_hold_p1[3] & ncs_hold_p1;

  // Stage p2: register file commit on the synchronised rising edge.
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      ram_en   <= 1'b0;
      rom_lo   <= 8'h00;
      rom_hi   <= '0;
      ram_bank <= '0;
      mode     <= 1'b0;
    end else if (commit) begin
      case (a_hold_p1[2:0])
        3'b000, 3'b001: ram_en <= (d_hold_p1[3:0] == 4'hA);
        3'b010:         rom_lo <= d_hold_p1;
        3'b011: begin
          if (ROM_BANK_W > 8)
            rom_hi <= d_hold_p1[HI_W-1:0];
        end
        3'b100, 3'b101: ram_bank <= d_hold_p1[RAM_BANK_W-1:0];
        default:        mode <= d_hold_p1[0];
      endcase
    end
  end

  generate
    if (ROM_BANK_W > 8) begin : g_split
      assign rom_bank    = {rom_hi, rom_lo};
      assign rom_hi_page = {rom_hi, 8'h00};
    end else begin : g_lo_only
      assign rom_bank    = rom_lo;
      assign rom_hi_page = '0;
    end
  endgenerate

  always_comb begin
    RA = '0;
    if (A14) begin
`ifdef MBC_GEN2_ZERO_BANK_FIX_EN
      RA = (rom_bank == '0) ? {{(ROM_BANK_W-1){1'b0}}, 1'b1} : rom_bank;
`else
      RA = rom_bank;
`endif
    end else if (mode) begin
      RA = rom_hi_page;
    end
  end

  assign AA       = ram_bank;
  assign RAM_CS   = ram_en & ~n_CS & ~A14 & A13 & n_RESET;
  assign n_RAM_CS = ~RAM_CS;

endmodule

// File: tb/tb_mbc_gen2.sv
// Directed-vector bench for mbc_gen2 with default widths (ROM 9 bits, RAM 4 bits).
module tb_mbc_gen2;

  logic       CLK;
  logic       n_RESET;
  logic [7:0] D;
  logic       A15, A14, A13, A12;
  logic       n_WR;
  logic       n_CS;
  logic [8:0] RA;
  logic [3:0] AA;
  logic       RAM_CS;
  logic       n_RAM_CS;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MBC_GEN2_ZERO_BANK_FIX_EN
  localparam logic [8:0] ZB = 9'h001;
`else
  localparam logic [8:0] ZB = 9'h000;
`endif

  mbc_gen2 #(.ROM_BANK_W(9), .RAM_BANK_W(4)) dut (
    .CLK(CLK), .n_RESET(n_RESET), .D(D),
    .A15(A15), .A14(A14), .A13(A13), .A12(A12),
    .n_WR(n_WR), .n_CS(n_CS),
    .RA(RA), .AA(AA), .RAM_CS(RAM_CS), .n_RAM_CS(n_RAM_CS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data,
                           input logic ncs, input int low_clks);
    @(negedge CLK);
    {A15, A14, A13, A12} = addr[15:12];
    D    = data;
    n_CS = ncs;
    n_WR = 1'b0;
    repeat (low_clks) @(negedge CLK);
    n_WR = 1'b1;
    repeat (4) @(negedge CLK);
    n_CS = 1'b1;
  endtask

  task automatic look(input logic a14, input logic a13, input logic ncs);
    @(negedge CLK);
    A14  = a14;
    A13  = a13;
    n_CS = ncs;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    logic ok;
    n_RESET = 1'b0;
    n_WR = 1'b1; n_CS = 1'b1; D = 8'h00;
    A15 = 1'b0; A14 = 1'b1; A13 = 1'b0; A12 = 1'b0;
    repeat (3) @(negedge CLK);
    n_RESET = 1'b1;
    repeat (5) @(negedge CLK);
    #1;
    check("rst_ra",      RA,       ZB);
    check("rst_aa",      AA,       4'h0);
    check("rst_ram_cs",  RAM_CS,   1'b0);
    check("rst_nram_cs", n_RAM_CS, 1'b1);

    // reset asserted mid-strobe, released with n_WR still low
    @(negedge CLK);
    {A15, A14, A13, A12} = 4'b0010; D = 8'h33; n_CS = 1'b1; n_WR = 1'b0;
    repeat (2) @(negedge CLK);
    n_RESET = 1'b0;
    repeat (2) @(negedge CLK);
    n_RESET = 1'b1;
    repeat (3) @(negedge CLK);
    n_WR = 1'b1;
    repeat (5) @(negedge CLK);
    look(1'b1, 1'b0, 1'b1);
    check("midrst_discard", RA, ZB);
    bus_write(16'h2000, 8'h33, 1'b1, 3);
    look(1'b1, 1'b0, 1'b1);
    check("midrst_next_write", RA, 9'h033);

    // ROM banking and commit latency
    bus_write(16'h2000, 8'h5A, 1'b1, 3);
    @(negedge CLK);
    {A15, A14, A13, A12} = 4'b0011; D = 8'h01; n_CS = 1'b1; n_WR = 1'b0;
    repeat (3) @(negedge CLK);
    n_WR = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    A14 = 1'b1;
    #1;
    check("lat_edge2", RA, 9'h05A);
    @(negedge CLK);
    #1;
    check("lat_edge3", RA, 9'h15A);
    repeat (3) @(negedge CLK);

    // RAM enable key and chip select decode
    bus_write(16'h0000, 8'h3A, 1'b1, 3);
    look(1'b0, 1'b1, 1'b0);
    check("ramcs_on",   RAM_CS,   1'b1);
    check("nramcs_on",  n_RAM_CS, 1'b0);
    look(1'b0, 1'b0, 1'b0);
    check("ramcs_a13_lo", RAM_CS, 1'b0);
    look(1'b1, 1'b1, 1'b0);
    check("ramcs_a14_hi", RAM_CS, 1'b0);
    bus_write(16'h0000, 8'h0B, 1'b1, 3);
    look(1'b0, 1'b1, 1'b0);
    check("ramcs_off", RAM_CS, 1'b0);

    bus_write(16'h4000, 8'hF7, 1'b1, 3);
    #1;
    check("aa_bank7", AA, 4'h7);

    // mode select
    look(1'b0, 1'b0, 1'b1);
    check("mode0_lower", RA, 9'h000);
    bus_write(16'h6000, 8'h01, 1'b1, 3);
    look(1'b0, 1'b0, 1'b1);
    check("mode1_lower", RA, 9'h100);
    look(1'b1, 1'b0, 1'b1);
    check("mode1_upper", RA, 9'h15A);

    // writes that must be ignored
    bus_write(16'hA000, 8'hFF, 1'b0, 3);
    look(1'b1, 1'b0, 1'b1);
    check("ign_a000_upper", RA, 9'h15A);
    look(1'b0, 1'b0, 1'b1);
    check("ign_a000_lower", RA, 9'h100);
    bus_write(16'h4000, 8'h02, 1'b0, 3);
    #1;
    check("ign_ncs_low", AA, 4'h7);
    bus_write(16'hC000, 8'h00, 1'b1, 3);
    #1;
    check("ign_a15_hi", AA, 4'h7);

    // short strobe: either no change or a full commit
    bus_write(16'h4000, 8'h05, 1'b1, 1);
    #1;
    ok = (AA == 4'h7) || (AA == 4'h5);
    check("short_pulse_whole", ok, 1'b1);
    bus_write(16'h4000, 8'h03, 1'b1, 2);
    #1;
    check("two_clk_pulse", AA, 4'h3);

    // asynchronous reset forces RAM_CS low and clears registers
    bus_write(16'h0000, 8'h0A, 1'b1, 3);
    look(1'b0, 1'b1, 1'b0);
    check("reen_ramcs", RAM_CS, 1'b1);
    #2;
    n_RESET = 1'b0;
    #1;
    check("async_rst_ramcs",  RAM_CS,   1'b0);
    check("async_rst_nramcs", n_RAM_CS, 1'b1);
    repeat (2) @(negedge CLK);
    n_RESET = 1'b1;
    #1;
    check("post_rst_ramcs", RAM_CS, 1'b0);
    check("post_rst_aa",    AA,     4'h0);
    look(1'b1, 1'b0, 1'b1);
    check("zero_bank_upper", RA, ZB);
    look(1'b0, 1'b0, 1'b1);
    check("post_rst_mode", RA, 9'h000);
    repeat (4) @(negedge CLK);

    // consecutive writes, both committed
    bus_write(16'h2000, 8'h12, 1'b1, 2);
    bus_write(16'h3000, 8'h01, 1'b1, 2);
    look(1'b1, 1'b0, 1'b1);
    check("b2b_rom", RA, 9'h112);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
